// File: rtl/semaforo_pkg.sv
// Shared definitions for the semaforo_n traffic-light controller:
// state encoding, lamp codes, default phase durations and the via helper.
package semaforo_pkg;

  typedef enum logic [2:0] {
    VERDE          = 3'd0,
    AMARELO        = 3'd1,
    TODOS_VERMELHO = 3'd2,
    PEDESTRE       = 3'd3,
    PISCA          = 3'd4
  } estado_t;

  // Lamp codes per approach, ordered {vermelho, amarelo, verde}.
  localparam logic [2:0] LUZ_VERDE    = 3'b001;
  localparam logic [2:0] LUZ_AMARELO  = 3'b010;
  localparam logic [2:0] LUZ_VERMELHO = 3'b100;
  localparam logic [2:0] LUZ_APAGADO  = 3'b000;

  localparam logic [7:0] T_VERDE_DEF    = 8'd3;
  localparam logic [7:0] T_AMARELO_DEF  = 8'd3;
  localparam logic [7:0] T_VERMELHO_DEF = 8'd3;
  localparam logic [7:0] T_PED_DEF      = 8'd3;

  // Next approach index, wrapping from the last approach back to 0.
  function automatic logic [2:0] prox_via(input logic [2:0] v, input logic [2:0] ultimo);
    return (v == ultimo) ? 3'd0 : v + 3'd1;
  endfunction

endpackage

// File: rtl/semaforo_if.sv
// Lamp/request bundle between the controller and its environment.
// All signals are plain levels: bt and modo are sampled on every rising
// clock edge (no valid/ready handshake); luz, ped, via and estado are
// registered by the controller and valid throughout each clock cycle.
interface semaforo_if #(
  parameter int N_VIAS = 2
);
  import semaforo_pkg::*;

  logic                  bt;
  logic                  modo;
  logic [3*N_VIAS-1:0]   luz;
  logic                  ped;
  logic [2:0]            via;
  estado_t               estado;

  modport master (input bt, modo, output luz, ped, via, estado);
  modport slave  (output bt, modo, input luz, ped, via, estado);

endinterface

// File: rtl/semaforo_temporizador.sv
// 8-bit phase timer: cleared on request, flags the last cycle of a phase
// lasting dur cycles (dur = 1 means every cycle is the last one).
module temporizador (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [7:0] dur,
  output logic       fim
);

  logic [7:0] cnt;

  // Count cycles since the last clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= cnt + 8'd1;
  end

  assign fim = (cnt == dur - 8'd1);

endmodule

// File: rtl/semaforo_n.sv
// N-approach traffic-light controller with pedestrian phase and
// flashing-yellow night mode. Lamp outputs are registered from the
// next-state decode, so bt/modo never reach the outputs combinationally.
module semaforo_n
  import semaforo_pkg::*;
#(
  parameter int         N_VIAS     = 2,
  parameter logic [7:0] T_VERDE    = T_VERDE_DEF,
  parameter logic [7:0] T_AMARELO  = T_AMARELO_DEF,
  parameter logic [7:0] T_VERMELHO = T_VERMELHO_DEF,
  parameter logic [7:0] T_PED      = T_PED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  semaforo_if.master  bus
);

  localparam int         W      = 3 * N_VIAS;
  localparam logic [2:0] ULTIMA = 3'(N_VIAS - 1);

  if (N_VIAS < 2 || N_VIAS > 8) begin : g_chk_vias
    $error("semaforo_n: N_VIAS must be in 2..8");
  end
  if (T_VERDE == 8'd0 || T_AMARELO == 8'd0 || T_VERMELHO == 8'd0 || T_PED == 8'd0) begin : g_chk_t
    $error("semaforo_n: all durations must be in 1..255");
  end

  estado_t    estado, estado_nxt;
  logic [2:0] via, via_nxt;
  logic       pendente, pendente_nxt;
  logic       fase, fase_nxt;
  logic       fim, clr;
  logic [7:0] dur;

  // Lamp pattern for a given state, owning approach and blink phase.
  function automatic logic [W-1:0] luz_de(input estado_t e, input logic [2:0] v, input logic f);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N_VIAS; k++) begin
      case (e)
        VERDE:   r[3*k +: 3] = (3'(k) == v) ? LUZ_VERDE : LUZ_VERMELHO;
        AMARELO: r[3*k +: 3] = (3'(k) == v) ? LUZ_AMARELO : LUZ_VERMELHO;
        PISCA:   r[3*k +: 3] = f ? LUZ_APAGADO : LUZ_AMARELO;
        default: r[3*k +: 3] = LUZ_VERMELHO;
      endcase
    end
    return r;
  endfunction

  // Duration of the phase currently being timed; night mode blinks at the yellow rate.
  always_comb begin
    dur = T_VERDE;
    case (estado)
      VERDE:          dur = T_VERDE;
      AMARELO:        dur = T_AMARELO;
      TODOS_VERMELHO: dur = T_VERMELHO;
      PEDESTRE:       dur = T_PED;
      PISCA:          dur = T_AMARELO;
      default:        dur = T_VERDE;
    endcase
  end

  // Next-state decode; night mode overrides any running timer.
  always_comb begin
    estado_nxt   = estado;
    via_nxt      = via;
    pendente_nxt = pendente;
    fase_nxt     = fase;
    if (bus.modo) begin
      estado_nxt   = PISCA;
      pendente_nxt = 1'b0;
      if (estado != PISCA) fase_nxt = 1'b0;
      else if (fim)        fase_nxt = ~fase;
    end else begin
      if (bus.bt && (estado inside {VERDE, AMARELO, TODOS_VERMELHO})) pendente_nxt = 1'b1;
      case (estado)
        VERDE:   if (fim) estado_nxt = AMARELO;
        AMARELO: begin
          if (fim) begin
            if (pendente) begin
              estado_nxt   = PEDESTRE;
              pendente_nxt = 1'b0;
            end else begin
              estado_nxt = TODOS_VERMELHO;
            end
          end
        end
        TODOS_VERMELHO: begin
          if (fim) begin
            estado_nxt = VERDE;
            via_nxt    = prox_via(via, ULTIMA);
          end
        end
        PEDESTRE: if (fim) estado_nxt = TODOS_VERMELHO;
        PISCA: begin
          // Park on the last approach so the first green after night mode is approach 0.
          estado_nxt = TODOS_VERMELHO;
          via_nxt    = ULTIMA;
        end
        default: estado_nxt = VERDE;
      endcase
    end
  end

  // Timer restarts on every state entry and on every blink toggle.
  assign clr = (estado_nxt != estado) || ((estado == PISCA) && fim);

  temporizador u_temporizador (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .dur (dur),
    .fim (fim)
  );

  // Controller state and registered lamp outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado   <= VERDE;
      via      <= 3'd0;
      pendente <= 1'b0;
      fase     <= 1'b0;
      bus.luz  <= luz_de(VERDE, 3'd0, 1'b0);
      bus.ped  <= 1'b0;
    end else begin
      estado   <= estado_nxt;
      via      <= via_nxt;
      pendente <= pendente_nxt;
      fase     <= fase_nxt;
      bus.luz  <= luz_de(estado_nxt, via_nxt, fase_nxt);
      bus.ped  <= (estado_nxt == PEDESTRE);
    end
  end

  assign bus.via    = via;
  assign bus.estado = estado;

endmodule

// File: tb/tb_semaforo_n.sv
// Directed bench for semaforo_n: a 2-approach instance with T=3 and a
// 4-approach instance with T=1, both on the same clock and reset.
module tb_semaforo_n;
  import semaforo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [5:0] AG  = 6'b100_001;
  localparam logic [5:0] AY  = 6'b100_010;
  localparam logic [5:0] RR  = 6'b100_100;
  localparam logic [5:0] BG  = 6'b001_100;
  localparam logic [5:0] BY  = 6'b010_100;
  localparam logic [5:0] FL  = 6'b010_010;
  localparam logic [5:0] OFF = 6'b000_000;

  // Clock
  always #5 clk = ~clk;

  semaforo_if #(.N_VIAS(2)) bus2 ();
  semaforo_if #(.N_VIAS(4)) bus4 ();

  semaforo_n #(.N_VIAS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  semaforo_n #(
    .N_VIAS(4), .T_VERDE(8'd1), .T_AMARELO(8'd1), .T_VERMELHO(8'd1), .T_PED(8'd1)
  ) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // Expected 4-approach lamp word: approach v shows on_code, others red (v=-1: all red).
  function automatic logic [11:0] mk4(input logic [2:0] on_code, input int v);
    logic [11:0] r;
    for (int k = 0; k < 4; k++) r[3*k +: 3] = (k == v) ? on_code : 3'b100;
    return r;
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Reset both instances; returns 1 time unit after release (cycle 0 observable).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus2.bt = 1'b0; bus2.modo = 1'b0;
    bus4.bt = 1'b0; bus4.modo = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    bus2.bt = 1'b0; bus2.modo = 1'b0;
    bus4.bt = 1'b0; bus4.modo = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus2.luz, bus2.ped, bus2.via} !== {AG, 1'b0, 3'd0}) begin
      n_errors++;
      $display("FAIL reset_n2: got luz=%b ped=%b via=%0d, want luz=%b ped=0 via=0", bus2.luz, bus2.ped, bus2.via, AG);
    end
    n_checks++;
    if ({bus4.luz, bus4.ped, bus4.via} !== {mk4(3'b001, 0), 1'b0, 3'd0}) begin
      n_errors++;
      $display("FAIL reset_n4: got luz=%b ped=%b via=%0d, want luz=%b ped=0 via=0", bus4.luz, bus4.ped, bus4.via, mk4(3'b001, 0));
    end
    n_checks++;
    if (bus2.estado !== VERDE) begin
      n_errors++;
      $display("FAIL reset_state: got %0d want %0d", bus2.estado, VERDE);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus2.luz, bus2.ped, bus2.via} !== {AG, 1'b0, 3'd0}) begin
      n_errors++;
      $display("FAIL reset_release: got luz=%b ped=%b via=%0d, want luz=%b", bus2.luz, bus2.ped, bus2.via, AG);
    end
  endtask

  task automatic test_normal_cycle();
    logic [5:0] exp_l [19];
    logic [2:0] exp_v [19];
    exp_l = '{AG, AG, AG, AY, AY, AY, RR, RR, RR, BG, BG, BG, BY, BY, BY, RR, RR, RR, AG};
    exp_v = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
              3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    do_reset();
    for (int c = 0; c < 19; c++) begin
      n_checks++;
      if ({bus2.luz, bus2.ped, bus2.via} !== {exp_l[c], 1'b0, exp_v[c]}) begin
        n_errors++;
        $display("FAIL normal_cycle c=%0d: got luz=%b ped=%b via=%0d, want luz=%b ped=0 via=%0d",
                 c, bus2.luz, bus2.ped, bus2.via, exp_l[c], exp_v[c]);
      end
      if (c < 18) next_cycle();
    end
  endtask

  task automatic test_pedestrian();
    logic [5:0] exp_l [22];
    logic       exp_p [22];
    logic [2:0] exp_v [22];
    exp_l = '{AG, AG, AG, AY, AY, AY, RR, RR, RR, RR, RR, RR,
              BG, BG, BG, BY, BY, BY, RR, RR, RR, AG};
    for (int c = 0; c < 22; c++) begin
      exp_p[c] = (c >= 6 && c <= 8);
      exp_v[c] = (c >= 12 && c <= 20) ? 3'd1 : 3'd0;
    end
    do_reset();
    for (int c = 0; c < 22; c++) begin
      n_checks++;
      if ({bus2.luz, bus2.ped, bus2.via} !== {exp_l[c], exp_p[c], exp_v[c]}) begin
        n_errors++;
        $display("FAIL pedestrian c=%0d: got luz=%b ped=%b via=%0d, want luz=%b ped=%b via=%0d",
                 c, bus2.luz, bus2.ped, bus2.via, exp_l[c], exp_p[c], exp_v[c]);
      end
      bus2.bt = (c == 1 || c == 7);
      if (c < 21) next_cycle();
    end
    bus2.bt = 1'b0;
  endtask

  task automatic test_wrap4();
    logic [11:0] el;
    logic [2:0]  ev;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      ev = 3'((c / 3) % 4);
      case (c % 3)
        0:       el = mk4(3'b001, (c / 3) % 4);
        1:       el = mk4(3'b010, (c / 3) % 4);
        default: el = mk4(3'b100, -1);
      endcase
      n_checks++;
      if ({bus4.luz, bus4.ped, bus4.via} !== {el, 1'b0, ev}) begin
        n_errors++;
        $display("FAIL wrap4 c=%0d: got luz=%b ped=%b via=%0d, want luz=%b ped=0 via=%0d",
                 c, bus4.luz, bus4.ped, bus4.via, el, ev);
      end
      if (c < 12) next_cycle();
    end
  endtask

  task automatic test_night_mode();
    logic [5:0] el;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (c == 10) begin
        n_checks++;
        if ({bus2.luz, bus2.ped, bus2.via} !== {BG, 1'b0, 3'd1}) begin
          n_errors++;
          $display("FAIL night_pre c=%0d: got luz=%b ped=%b via=%0d, want luz=%b via=1", c, bus2.luz, bus2.ped, bus2.via, BG);
        end
      end else if (c >= 11 && c <= 19) begin
        el = (((c - 11) / 3) % 2 == 0) ? FL : OFF;
        n_checks++;
        if ({bus2.luz, bus2.ped} !== {el, 1'b0}) begin
          n_errors++;
          $display("FAIL night_blink c=%0d: got luz=%b ped=%b, want luz=%b ped=0", c, bus2.luz, bus2.ped, el);
        end
      end else if (c >= 20 && c <= 22) begin
        n_checks++;
        if ({bus2.luz, bus2.ped, bus2.via} !== {RR, 1'b0, 3'd1}) begin
          n_errors++;
          $display("FAIL night_exit c=%0d: got luz=%b ped=%b via=%0d, want luz=%b via=1", c, bus2.luz, bus2.ped, bus2.via, RR);
        end
      end else if (c == 23 || c == 26 || c == 29) begin
        el = (c == 23) ? AG : (c == 26) ? AY : RR;
        n_checks++;
        if ({bus2.luz, bus2.ped, bus2.via} !== {el, 1'b0, 3'd0}) begin
          n_errors++;
          $display("FAIL night_after c=%0d: got luz=%b ped=%b via=%0d, want luz=%b ped=0 via=0", c, bus2.luz, bus2.ped, bus2.via, el);
        end
      end
      bus2.bt = (c == 9);
      if (c == 10) bus2.modo = 1'b1;
      if (c == 19) bus2.modo = 1'b0;
      if (c < 29) next_cycle();
    end
    bus2.bt = 1'b0;
    bus2.modo = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      bus2.bt = (c == 1);
      next_cycle();
    end
    bus2.bt = 1'b0;
    n_checks++;
    if ({bus2.luz, bus2.ped} !== {RR, 1'b1}) begin
      n_errors++;
      $display("FAIL async_pre: got luz=%b ped=%b, want luz=%b ped=1", bus2.luz, bus2.ped, RR);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus2.luz, bus2.ped, bus2.via} !== {AG, 1'b0, 3'd0}) begin
      n_errors++;
      $display("FAIL async_assert: got luz=%b ped=%b via=%0d, want luz=%b ped=0 via=0", bus2.luz, bus2.ped, bus2.via, AG);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (c == 2 || c == 3 || c == 6 || c == 9) begin
        n_checks++;
        case (c)
          2: if ({bus2.luz, bus2.ped, bus2.via} !== {AG, 1'b0, 3'd0}) begin
               n_errors++;
               $display("FAIL async_after c=2: got luz=%b ped=%b via=%0d, want luz=%b", bus2.luz, bus2.ped, bus2.via, AG);
             end
          3: if ({bus2.luz, bus2.ped, bus2.via} !== {AY, 1'b0, 3'd0}) begin
               n_errors++;
               $display("FAIL async_after c=3: got luz=%b ped=%b via=%0d, want luz=%b", bus2.luz, bus2.ped, bus2.via, AY);
             end
          6: if ({bus2.luz, bus2.ped, bus2.via} !== {RR, 1'b0, 3'd0}) begin
               n_errors++;
               $display("FAIL async_after c=6: got luz=%b ped=%b via=%0d, want luz=%b ped=0", bus2.luz, bus2.ped, bus2.via, RR);
             end
          default: if ({bus2.luz, bus2.ped, bus2.via} !== {BG, 1'b0, 3'd1}) begin
               n_errors++;
               $display("FAIL async_after c=9: got luz=%b ped=%b via=%0d, want luz=%b via=1", bus2.luz, bus2.ped, bus2.via, BG);
             end
        endcase
      end
      if (c < 9) next_cycle();
    end
  endtask

  initial begin
    bus2.bt = 1'b0; bus2.modo = 1'b0;
    bus4.bt = 1'b0; bus4.modo = 1'b0;
    test_reset();
    test_normal_cycle();
    test_pedestrian();
    test_wrap4();
    test_night_mode();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
